z80_bus_responder: RTL and testbench

Memory/IO responder for the Z80 core's external bus: the device on the far side of the address, data and control pins. It decodes Z80 bus cycles and serves memory reads and writes from an internal RAM. It also serves a GPIO port pair, inserts optional wait states, and raises and acknowledges a mode-2 style interrupt. It runs in the core's clock domain and sits between the Z80 pad-side signals and on-chip test/bring-up logic.

---
 rtl/z80_bus_pkg.sv | 31 +++
 rtl/z80_resp_ram.sv | 39 +++
 rtl/z80_bus_responder.sv | 276 +++++++++++++++++++++++++++
 tb/tb_z80_bus_responder.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/z80_bus_pkg.sv
// -----------------------------------------------------------------------------
// z80_bus_pkg
//
// Shared definitions for the Z80 bus responder:
//   - bus_state_t   : bus-cycle FSM states (IDLE .. INTA)
//   - PORT_GPIO_OUT : IO port holding the GPIO output register (read/write)
//   - PORT_GPIO_IN  : IO port returning the GPIO input pins (read only)
//   - UNMAPPED_DATA : value returned for unmapped memory and unknown IO ports
//   - in_ram()      : address decode helper for the RAM window at 0x0000
// -----------------------------------------------------------------------------
package z80_bus_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        MEM_RD = 3'd1,
        MEM_WR = 3'd2,
        IO_RD  = 3'd3,
        IO_WR  = 3'd4,
        INTA   = 3'd5
    } bus_state_t;

    localparam logic [7:0] PORT_GPIO_OUT = 8'h00;
    localparam logic [7:0] PORT_GPIO_IN  = 8'h01;
    localparam logic [7:0] UNMAPPED_DATA = 8'hFF;

    // RAM occupies 0x0000 .. 2^aw-1; everything above it is unmapped.
    function automatic logic in_ram(input logic [15:0] a, input int aw);
        return (a >> aw) == 16'h0000;
    endfunction

endpackage

// File: rtl/z80_resp_ram.sv
// -----------------------------------------------------------------------------
// z80_resp_ram
//
// Single-port synchronous RAM, 2^AW x 8, one access per clock. A write takes
// priority; otherwise an enabled read updates the registered read data, which
// holds its value between reads.
//
// Ports:
//   clk    in   clock
//   en     in   read enable
//   we     in   write enable
//   addr   in   AW   byte address
//   wdata  in   8    write data
//   rdata  out  8    registered read data
// -----------------------------------------------------------------------------
module z80_resp_ram #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);

    logic [7:0] mem [2**AW];

    // NOTE: the array has no reset so it maps onto block RAM; contents are
    // only defined once written.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end else if (en) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/z80_bus_responder.sv
// -----------------------------------------------------------------------------
// z80_bus_responder
//
// Far-side device on the Z80 external bus. Decodes bus cycles from the
// registered control strobes and serves:
//   - memory reads/writes to an internal 2^MEM_AW byte RAM at 0x0000
//     (addresses above it read 0xFF, writes there are dropped),
//   - IO port 0x00 (gpio_out, read/write) and 0x01 (gpio_in, read only),
//     other ports read 0xFF,
//   - interrupt acknowledge: drives IRQ_VECTOR and clears the pending request.
//
// Optional feature (macro Z80_BUS_RESPONDER_WAIT_EN): drive wait_n low for
// WAIT_CYCLES clocks from every memory/IO/INTA cycle start. Without the macro
// wait_n is tied high and WAIT_CYCLES is only range-checked.
//
// Parameters:
//   MEM_AW       RAM address width (RAM size 2^MEM_AW bytes)
//   WAIT_CYCLES  wait states per cycle, 1..15
//   IRQ_VECTOR   byte driven during interrupt acknowledge
//
// Ports:
//   wb_clk_i       in   1   clock shared with the Z80 core
//   wb_rst_i       in   1   asynchronous active-high reset
//   addr           in   16  Z80 address bus
//   m1_n .. rfsh_n in   1   Z80 control strobes, active low
//   data_from_cpu  in   8   Z80 data bus output
//   data_to_cpu    out  8   read / vector data towards the Z80
//   data_oe        out  1   data_to_cpu owns the bus
//   wait_n         out  1   Z80 WAIT, active low
//   int_n          out  1   Z80 INT, active low
//   irq_i          in   1   one-clock interrupt request pulse
//   gpio_in        in   8   value read on port 0x01
//   gpio_out       out  8   register written on port 0x00
// -----------------------------------------------------------------------------
module z80_bus_responder
    import z80_bus_pkg::*;
#(
    parameter int         MEM_AW      = 8,
    parameter int         WAIT_CYCLES = 2,
    parameter logic [7:0] IRQ_VECTOR  = 8'hFF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [15:0] addr,
    input  logic        m1_n,
    input  logic        mreq_n,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic        rfsh_n,
    input  logic [7:0]  data_from_cpu,
    output logic [7:0]  data_to_cpu,
    output logic        data_oe,
    output logic        wait_n,
    output logic        int_n,
    input  logic        irq_i,
    input  logic [7:0]  gpio_in,
    output logic [7:0]  gpio_out
);

    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_wait_range_check
        $error("z80_bus_responder: WAIT_CYCLES must be in 1..15");
    end

    // -------------------------------------------------------------------------
    // Pin sampling. The *_q copies are the strobes as sampled this clock, the
    // *_qq copies the previous sample, used for falling-edge detection.
    // -------------------------------------------------------------------------
    logic        m1_q, mreq_q, iorq_q, rd_q, wr_q, rfsh_q;
    logic        mreq_qq, iorq_qq, rd_qq, wr_qq;
    logic [15:0] addr_q;
    logic [7:0]  data_q;

    // NOTE: every register here uses <= so all flops update from the values
    // present before the edge, whatever the statement order.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            m1_q    <= 1'b1;
            mreq_q  <= 1'b1;
            iorq_q  <= 1'b1;
            rd_q    <= 1'b1;
            wr_q    <= 1'b1;
            rfsh_q  <= 1'b1;
            mreq_qq <= 1'b1;
            iorq_qq <= 1'b1;
            rd_qq   <= 1'b1;
            wr_qq   <= 1'b1;
            addr_q  <= 16'h0000;
            data_q  <= 8'h00;
        end else begin
            m1_q    <= m1_n;
            mreq_q  <= mreq_n;
            iorq_q  <= iorq_n;
            rd_q    <= rd_n;
            wr_q    <= wr_n;
            rfsh_q  <= rfsh_n;
            mreq_qq <= mreq_q;
            iorq_qq <= iorq_q;
            rd_qq   <= rd_q;
            wr_qq   <= wr_q;
            addr_q  <= addr;
            data_q  <= data_from_cpu;
        end
    end

    // -------------------------------------------------------------------------
    // Cycle-start decode
    // -------------------------------------------------------------------------
    bus_state_t state;
    bus_state_t start_kind;
    logic       strobe_fell;
    logic       start;

    // A write cycle drops mreq_n before wr_n, so any strobe edge may be the one
    // that completes a qualifying combination.
    assign strobe_fell = (mreq_qq & ~mreq_q) | (iorq_qq & ~iorq_q) |
                         (rd_qq & ~rd_q)     | (wr_qq & ~wr_q);

    // NOTE: start_kind gets a default first so no path through the block
    // leaves it unassigned and infers a latch.
    always_comb begin
        start_kind = IDLE;
        if (!mreq_q && !rd_q && rfsh_q) begin
            start_kind = MEM_RD;
        end else if (!mreq_q && !wr_q && rfsh_q) begin
            start_kind = MEM_WR;
        end else if (!iorq_q && !m1_q) begin
            start_kind = INTA;
        end else if (!iorq_q && !rd_q) begin
            start_kind = IO_RD;
        end else if (!iorq_q && !wr_q) begin
            start_kind = IO_WR;
        end
    end

    // Refresh (mreq_n & rfsh_n low) decodes to IDLE and never starts a cycle.
    assign start = (state == IDLE) && strobe_fell && (start_kind != IDLE);

    // -------------------------------------------------------------------------
    // Cycle context and RAM port
    // -------------------------------------------------------------------------
    logic [15:0] cyc_addr;    // address captured at cycle start
    logic [7:0]  cyc_data;    // last data seen while wr_n was low
    logic        wr_done;     // the single write of this cycle has happened
    logic        load_q;      // cycle started last clock: load data_to_cpu
    logic        pending;
    logic        wr_fire;
    logic        ram_we;
    logic        ram_en;
    logic [MEM_AW-1:0] ram_addr;
    logic [7:0]  ram_rdata;
    logic [7:0]  io_read_data;

    // Fires once, on the first clock wr_n is sampled high inside a write cycle.
    assign wr_fire  = ((state == MEM_WR) || (state == IO_WR)) && wr_q && !wr_done;
    assign ram_we   = wr_fire && (state == MEM_WR) && in_ram(cyc_addr, MEM_AW);
    assign ram_en   = start && (start_kind == MEM_RD);
    assign ram_addr = ram_we ? cyc_addr[MEM_AW-1:0] : addr_q[MEM_AW-1:0];

    z80_resp_ram #(
        .AW(MEM_AW)
    ) u_ram (
        .clk   (wb_clk_i),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (cyc_data),
        .rdata (ram_rdata)
    );

    always_comb begin
        io_read_data = UNMAPPED_DATA;
        if (cyc_addr[7:0] == PORT_GPIO_OUT) begin
            io_read_data = gpio_out;
        end else if (cyc_addr[7:0] == PORT_GPIO_IN) begin
            io_read_data = gpio_in;
        end
    end

    // -------------------------------------------------------------------------
    // Bus-cycle FSM with its registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state       <= IDLE;
            cyc_addr    <= 16'h0000;
            cyc_data    <= 8'h00;
            wr_done     <= 1'b0;
            load_q      <= 1'b0;
            pending     <= 1'b0;
            data_to_cpu <= 8'h00;
            gpio_out    <= 8'h00;
        end else begin
            load_q <= start;

            if (!wr_q) begin
                cyc_data <= data_q;
            end

            // A request arriving with the INTA start wins over the clear.
            if (irq_i) begin
                pending <= 1'b1;
            end else if (start && (start_kind == INTA)) begin
                pending <= 1'b0;
            end

            // The RAM read issued at cycle start lands one clock later, so all
            // read data is loaded then and held until the next cycle start.
            if (load_q) begin
                case (state)
                    MEM_RD:  data_to_cpu <= in_ram(cyc_addr, MEM_AW) ? ram_rdata
                                                                     : UNMAPPED_DATA;
                    IO_RD:   data_to_cpu <= io_read_data;
                    INTA:    data_to_cpu <= IRQ_VECTOR;
                    default: data_to_cpu <= data_to_cpu;
                endcase
            end

            if (wr_fire) begin
                wr_done <= 1'b1;
                if ((state == IO_WR) && (cyc_addr[7:0] == PORT_GPIO_OUT)) begin
                    gpio_out <= cyc_data;
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= start_kind;
                        cyc_addr <= addr_q;
                        wr_done  <= 1'b0;
                    end
                end
                MEM_RD, MEM_WR: begin
                    if (mreq_q) begin
                        state <= IDLE;
                    end
                end
                IO_RD, IO_WR, INTA: begin
                    if (iorq_q) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Follows the live strobe so the bus is released in the same clock.
    assign data_oe = (((state == MEM_RD) || (state == IO_RD)) && !rd_n) ||
                     ((state == INTA) && !iorq_n);

    assign int_n = ~pending;

    // -------------------------------------------------------------------------
    // Wait-state generator
    // -------------------------------------------------------------------------
`ifdef Z80_BUS_RESPONDER_WAIT_EN
    logic [3:0] wait_cnt;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wait_cnt <= 4'd0;
        end else if (start) begin
            wait_cnt <= 4'(WAIT_CYCLES);
        end else if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    assign wait_n = (wait_cnt == 4'd0);
`else
    assign wait_n = 1'b1;
`endif

endmodule

// File: tb/tb_z80_bus_responder.sv
// -----------------------------------------------------------------------------
// tb_z80_bus_responder
//
// Drives Z80-style bus cycles at the pins of z80_bus_responder: a directed
// vector table, hand-written multi-cycle sequences (GPIO timing, interrupts,
// wait states, reset mid-write) and a randomized run against a reference
// model built from a byte array, a GPIO variable and a pending flag.
// -----------------------------------------------------------------------------
module tb_z80_bus_responder;

    localparam int         MEM_AW      = 8;
    localparam int         WAIT_CYCLES = 3;
    localparam logic [7:0] IRQ_VECTOR  = 8'hC7;
    localparam int         RAM_BYTES   = 1 << MEM_AW;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic [15:0] addr;
    logic        m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n;
    logic [7:0]  data_from_cpu;
    logic [7:0]  data_to_cpu;
    logic        data_oe;
    logic        wait_n;
    logic        int_n;
    logic        irq_i;
    logic [7:0]  gpio_in;
    logic [7:0]  gpio_out;

    z80_bus_responder #(
        .MEM_AW      (MEM_AW),
        .WAIT_CYCLES (WAIT_CYCLES),
        .IRQ_VECTOR  (IRQ_VECTOR)
    ) dut (
        .wb_clk_i      (wb_clk_i),
        .wb_rst_i      (wb_rst_i),
        .addr          (addr),
        .m1_n          (m1_n),
        .mreq_n        (mreq_n),
        .iorq_n        (iorq_n),
        .rd_n          (rd_n),
        .wr_n          (wr_n),
        .rfsh_n        (rfsh_n),
        .data_from_cpu (data_from_cpu),
        .data_to_cpu   (data_to_cpu),
        .data_oe       (data_oe),
        .wait_n        (wait_n),
        .int_n         (int_n),
        .irq_i         (irq_i),
        .gpio_in       (gpio_in),
        .gpio_out      (gpio_out)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int checks   = 0;
    int failures = 0;

    // Reference model
    logic [7:0] model_mem [int];
    logic [7:0] model_gpio;
    bit         model_pending;

`ifdef Z80_BUS_RESPONDER_WAIT_EN
    localparam int EXP_WAIT = WAIT_CYCLES;
`else
    localparam int EXP_WAIT = 0;
`endif

    typedef enum { OP_MWR, OP_MRD, OP_IOWR, OP_IORD, OP_RFSH } op_t;

    typedef struct {
        op_t        op;
        logic [15:0] a;
        logic [7:0]  wd;
        logic [7:0]  gin;
        logic [7:0]  exp_d;   // read data, or gpio_out after an IO write
        logic        exp_oe;
    } vec_t;

    vec_t vecs[$];

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge wb_clk_i);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic bus_idle();
        m1_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1;
        rd_n = 1'b1; wr_n = 1'b1; rfsh_n = 1'b1;
    endtask

    task automatic mem_read(input logic [15:0] a, output logic [7:0] d, output logic oe);
        addr = a; mreq_n = 1'b0; rd_n = 1'b0;
        tick(4);
        d = data_to_cpu; oe = data_oe;
        mreq_n = 1'b1; rd_n = 1'b1;
        tick(1);
        check("mem_rd_oe_release", {7'd0, data_oe}, 8'h00);
    endtask

    task automatic mem_write(input logic [15:0] a, input logic [7:0] d);
        addr = a; data_from_cpu = d; mreq_n = 1'b0;
        tick(1);
        wr_n = 1'b0;
        tick(3);
        wr_n = 1'b1; mreq_n = 1'b1;
        tick(1);
    endtask

    task automatic io_write(input logic [15:0] a, input logic [7:0] d);
        addr = a; data_from_cpu = d; iorq_n = 1'b0; wr_n = 1'b0;
        tick(4);
        iorq_n = 1'b1; wr_n = 1'b1;
        tick(1);
    endtask

    task automatic io_read(input logic [15:0] a, input logic [7:0] gin,
                           output logic [7:0] d, output logic oe);
        addr = a; gpio_in = gin; iorq_n = 1'b0; rd_n = 1'b0;
        tick(4);
        d = data_to_cpu; oe = data_oe;
        iorq_n = 1'b1; rd_n = 1'b1;
        tick(1);
        check("io_rd_oe_release", {7'd0, data_oe}, 8'h00);
    endtask

    // Interrupt acknowledge; optionally pulses irq_i in the cycle-start clock.
    task automatic inta(input bit irq_at_start, output logic [7:0] d,
                        output logic oe, output logic intn);
        m1_n = 1'b0;
        tick(1);
        iorq_n = 1'b0;
        tick(1);
        if (irq_at_start) irq_i = 1'b1;
        tick(1);
        irq_i = 1'b0;
        tick(2);
        d = data_to_cpu; oe = data_oe; intn = int_n;
        m1_n = 1'b1; iorq_n = 1'b1;
        tick(1);
    endtask

    task automatic refresh(input logic [15:0] a, output logic oe_seen, output int wait_low);
        oe_seen = 1'b0; wait_low = 0;
        addr = a; data_from_cpu = 8'hEE; mreq_n = 1'b0; rfsh_n = 1'b0;
        repeat (4) begin
            tick(1);
            if (data_oe) oe_seen = 1'b1;
            if (!wait_n) wait_low++;
        end
        mreq_n = 1'b1; rfsh_n = 1'b1;
        tick(1);
    endtask

    task automatic pulse_irq();
        irq_i = 1'b1;
        tick(1);
        irq_i = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data_to_cpu"}, data_to_cpu, 8'h00);
        check({tag, "_data_oe"}, {7'd0, data_oe}, 8'h00);
        check({tag, "_wait_n"}, {7'd0, wait_n}, 8'h01);
        check({tag, "_int_n"}, {7'd0, int_n}, 8'h01);
        check({tag, "_gpio_out"}, gpio_out, 8'h00);
    endtask

    function automatic vec_t mk(op_t op, logic [15:0] a, logic [7:0] wd,
                                logic [7:0] gin, logic [7:0] exp_d, logic exp_oe);
        vec_t v;
        v.op = op; v.a = a; v.wd = wd; v.gin = gin; v.exp_d = exp_d; v.exp_oe = exp_oe;
        return v;
    endfunction

    initial begin
        logic [7:0] d;
        logic       oe;
        logic       intn;
        logic       oe_seen;
        int         wl;

        bus_idle();
        wb_rst_i = 1'b1;
        addr = 16'h0000; data_from_cpu = 8'h00; irq_i = 1'b0; gpio_in = 8'h00;

        // ---------------- Reset state ----------------
        tick(3);
        check_reset_outputs("reset");
        wb_rst_i = 1'b0;
        tick(2);
        check("post_reset_int_n", {7'd0, int_n}, 8'h01);

        // ---------------- Directed vector table ----------------
        vecs.push_back(mk(OP_MWR,  16'h0012, 8'hA5, 8'h00, 8'h00, 1'b0));
        vecs.push_back(mk(OP_MRD,  16'h0012, 8'h00, 8'h00, 8'hA5, 1'b1));
        vecs.push_back(mk(OP_MRD,  16'h8000, 8'h00, 8'h00, 8'hFF, 1'b1));
        vecs.push_back(mk(OP_MWR,  16'h8012, 8'h11, 8'h00, 8'h00, 1'b0));
        vecs.push_back(mk(OP_MRD,  16'h0012, 8'h00, 8'h00, 8'hA5, 1'b1));
        vecs.push_back(mk(OP_RFSH, 16'h0012, 8'h00, 8'h00, 8'h00, 1'b0));
        vecs.push_back(mk(OP_MRD,  16'h0012, 8'h00, 8'h00, 8'hA5, 1'b1));
        vecs.push_back(mk(OP_IOWR, 16'h1200, 8'h3C, 8'h00, 8'h3C, 1'b0));
        vecs.push_back(mk(OP_IORD, 16'h3401, 8'h00, 8'h5A, 8'h5A, 1'b1));
        vecs.push_back(mk(OP_IORD, 16'h0007, 8'h00, 8'h5A, 8'hFF, 1'b1));
        vecs.push_back(mk(OP_IORD, 16'hAB00, 8'h00, 8'h00, 8'h3C, 1'b1));
        vecs.push_back(mk(OP_MWR,  16'h00FF, 8'hC3, 8'h00, 8'h00, 1'b0));
        vecs.push_back(mk(OP_MRD,  16'h00FF, 8'h00, 8'h00, 8'hC3, 1'b1));
        vecs.push_back(mk(OP_MRD,  16'h0100, 8'h00, 8'h00, 8'hFF, 1'b1));
        vecs.push_back(mk(OP_IOWR, 16'h0005, 8'h99, 8'h00, 8'h3C, 1'b0));
        vecs.push_back(mk(OP_IORD, 16'h0000, 8'h00, 8'h00, 8'h3C, 1'b1));

        foreach (vecs[i]) begin
            case (vecs[i].op)
                OP_MWR: mem_write(vecs[i].a, vecs[i].wd);
                OP_MRD: begin
                    mem_read(vecs[i].a, d, oe);
                    check($sformatf("vec%0d_mem_rd_data", i), d, vecs[i].exp_d);
                    check($sformatf("vec%0d_mem_rd_oe", i), {7'd0, oe}, {7'd0, vecs[i].exp_oe});
                end
                OP_IOWR: begin
                    io_write(vecs[i].a, vecs[i].wd);
                    tick(1);
                    check($sformatf("vec%0d_gpio_out", i), gpio_out, vecs[i].exp_d);
                end
                OP_IORD: begin
                    io_read(vecs[i].a, vecs[i].gin, d, oe);
                    check($sformatf("vec%0d_io_rd_data", i), d, vecs[i].exp_d);
                    check($sformatf("vec%0d_io_rd_oe", i), {7'd0, oe}, {7'd0, vecs[i].exp_oe});
                end
                OP_RFSH: begin
                    refresh(vecs[i].a, oe_seen, wl);
                    check($sformatf("vec%0d_rfsh_oe", i), {7'd0, oe_seen}, 8'h00);
                    check($sformatf("vec%0d_rfsh_wait", i), 8'(wl), 8'h00);
                end
                default: ;
            endcase
        end

        // ---------------- GPIO write timing ----------------
        addr = 16'h0000; data_from_cpu = 8'h81; iorq_n = 1'b0; wr_n = 1'b0;
        tick(4);
        check("gpio_hold_while_wr_low", gpio_out, 8'h3C);
        iorq_n = 1'b1; wr_n = 1'b1;
        tick(2);
        check("gpio_after_wr_release", gpio_out, 8'h81);

        // ---------------- Interrupts ----------------
        check("int_n_idle", {7'd0, int_n}, 8'h01);
        pulse_irq();
        check("int_n_after_irq", {7'd0, int_n}, 8'h00);
        inta(1'b0, d, oe, intn);
        check("inta_vector", d, IRQ_VECTOR);
        check("inta_oe", {7'd0, oe}, 8'h01);
        check("inta_int_n_cleared", {7'd0, intn}, 8'h01);
        pulse_irq();
        inta(1'b1, d, oe, intn);
        check("inta_set_wins_vector", d, IRQ_VECTOR);
        check("inta_set_wins_int_n", {7'd0, intn}, 8'h00);
        inta(1'b0, d, oe, intn);
        check("inta_second_clear", {7'd0, intn}, 8'h01);

        // ---------------- Wait states ----------------
        wl = 0;
        addr = 16'h0012; mreq_n = 1'b0; rd_n = 1'b0;
        repeat (8) begin
            tick(1);
            if (!wait_n) wl++;
        end
        mreq_n = 1'b1; rd_n = 1'b1;
        tick(1);
        check("wait_low_clocks_mem_rd", 8'(wl), 8'(EXP_WAIT));
        refresh(16'h0012, oe_seen, wl);
        check("wait_low_clocks_refresh", 8'(wl), 8'h00);

        // ---------------- Reset in the middle of a write ----------------
        mem_write(16'h0020, 8'h77);
        io_write(16'h0000, 8'h5E);
        pulse_irq();
        addr = 16'h0020; data_from_cpu = 8'h99; mreq_n = 1'b0;
        tick(1);
        wr_n = 1'b0;
        tick(3);
        wb_rst_i = 1'b1;
        tick(1);
        check_reset_outputs("mid_write_reset");
        wr_n = 1'b1; mreq_n = 1'b1;
        tick(2);
        wb_rst_i = 1'b0;
        tick(2);
        mem_read(16'h0020, d, oe);
        check("mid_write_reset_ram_kept", d, 8'h77);
        check("mid_write_reset_gpio", gpio_out, 8'h00);

        // ---------------- Randomized run against the model ----------------
        model_gpio    = 8'h00;
        model_pending = 1'b0;
        for (int n = 0; n < 120; n++) begin
            logic [15:0] a;
            logic [7:0]  wd;
            logic [7:0]  gin;
            logic [7:0]  port;
            logic [7:0]  exp;
            int          sel;
            sel = int'($urandom_range(0, 6));
            if ($urandom_range(0, 3) == 0) a = 16'($urandom_range(RAM_BYTES, 16'hFFFF));
            else                           a = 16'($urandom_range(0, 15));
            wd   = 8'($urandom);
            gin  = 8'($urandom);
            case ($urandom_range(0, 3))
                0:       port = 8'h00;
                1:       port = 8'h01;
                2:       port = 8'($urandom_range(2, 255));
                default: port = 8'h00;
            endcase
            case (sel)
                0: begin
                    mem_write(a, wd);
                    if (int'(a) < RAM_BYTES) model_mem[int'(a)] = wd;
                end
                1, 2: begin
                    mem_read(a, d, oe);
                    check("rand_mem_rd_oe", {7'd0, oe}, 8'h01);
                    if (int'(a) >= RAM_BYTES) begin
                        check("rand_mem_rd_unmapped", d, 8'hFF);
                    end else if (model_mem.exists(int'(a))) begin
                        check($sformatf("rand_mem_rd_%04h", a), d, model_mem[int'(a)]);
                    end
                end
                3: begin
                    io_write({8'($urandom), port}, wd);
                    if (port == 8'h00) model_gpio = wd;
                    tick(1);
                    check("rand_gpio_out", gpio_out, model_gpio);
                end
                4: begin
                    io_read({8'($urandom), port}, gin, d, oe);
                    if (port == 8'h00)      exp = model_gpio;
                    else if (port == 8'h01) exp = gin;
                    else                    exp = 8'hFF;
                    check($sformatf("rand_io_rd_port%02h", port), d, exp);
                    check("rand_io_rd_oe", {7'd0, oe}, 8'h01);
                end
                5: begin
                    pulse_irq();
                    model_pending = 1'b1;
                    check("rand_int_n_after_irq", {7'd0, int_n}, {7'd0, ~model_pending});
                end
                default: begin
                    inta(1'b0, d, oe, intn);
                    model_pending = 1'b0;
                    check("rand_inta_vector", d, IRQ_VECTOR);
                    check("rand_inta_int_n", {7'd0, intn}, {7'd0, ~model_pending});
                end
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
